hybd_com_reader: RTL and testbench

Initiator end of the hybrid-core com_if (req/addr → rdy/data). On a start pulse it sweeps a configurable address range and reads each 16-bit word from the responder with a four-phase handshake. It then streams each word as two bytes, MSB first, to the UART transmit byte interface. It sits between the hybrid core's com_if and the UART TX path, and is typically started by the hybrid-done flag.

---
 rtl/hybd_com_pkg.sv | 17 +
 rtl/hybd_com_req_fsm.sv | 91 +++++++++
 rtl/hybd_com_reader.sv | 140 ++++++++++++++
 tb/tb_hybd_com_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hybd_com_pkg.sv
// Shared types and constants for the hybrid-core com_if reader.
package hybd_com_pkg;

    localparam int COM_ADDR_W = 7;
    localparam int COM_DATA_W = 16;

    localparam logic [COM_DATA_W-1:0] TIMEOUT_FILL = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_REL   = 3'd2,
        ST_TX_HI = 3'd3,
        ST_TX_LO = 3'd4
    } hybd_state_t;

endpackage

// File: rtl/hybd_com_req_fsm.sv
// Four-phase com_if read handshake (REQ/REL) for one word.
// Optional per-edge timeout is enabled with COM_RD_TIMEOUT_EN.
module hybd_com_req_fsm
    import hybd_com_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023,
    parameter int TIMEOUT_W   = 10
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  launch_i,
    input  logic [COM_ADDR_W-1:0] launch_addr_i,
    input  logic                  rdy_i,
    input  logic [COM_DATA_W-1:0] data_i,
    output logic                  req_o,
    output logic [COM_ADDR_W-1:0] addr_o,
    output logic [COM_DATA_W-1:0] word_o,
    output logic                  rd_done_o,
    output logic                  tmo_o
);

    hybd_state_t ph_q;
    logic        hit_s;

    if (TIMEOUT_W < $clog2(TIMEOUT_CYC + 1)) begin : g_bad_timeout_w
        $error("TIMEOUT_W too narrow for TIMEOUT_CYC");
    end

`ifdef COM_RD_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q;

    assign hit_s = (cnt_q == TIMEOUT_W'(TIMEOUT_CYC - 1));

    // Counts cycles spent waiting on the current rdy edge; zero on every phase entry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (!hit_s && (((ph_q == ST_REQ) && !rdy_i) || ((ph_q == ST_REL) && rdy_i))) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
`else
    assign hit_s = 1'b0;
`endif

    assign rd_done_o = (ph_q == ST_REL) && (!rdy_i || hit_s);
    assign tmo_o     = hit_s && (((ph_q == ST_REQ) && !rdy_i) || ((ph_q == ST_REL) && rdy_i));

    // Handshake sequencer: raise req, capture on rdy, then wait for rdy release.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ph_q   <= ST_IDLE;
            req_o  <= 1'b0;
            addr_o <= '0;
            word_o <= '0;
        end else begin
            case (ph_q)
                ST_IDLE: begin
                    if (launch_i) begin
                        ph_q   <= ST_REQ;
                        req_o  <= 1'b1;
                        addr_o <= launch_addr_i;
                    end
                end
                ST_REQ: begin
                    if (rdy_i) begin
                        word_o <= data_i;
                        req_o  <= 1'b0;
                        ph_q   <= ST_REL;
                    end else if (hit_s) begin
                        word_o <= TIMEOUT_FILL;
                        req_o  <= 1'b0;
                        ph_q   <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (rd_done_o) begin
                        ph_q <= ST_IDLE;
                    end
                end
                default: begin
                    ph_q  <= ST_IDLE;
                    req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hybd_com_reader.sv
// com_if initiator: sweeps an address range, reads each word and streams it MSB-first to UART TX.
// Optional read timeout: define COM_RD_TIMEOUT_EN.
module hybd_com_reader
    import hybd_com_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023,
    parameter int TIMEOUT_W   = 10
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [COM_ADDR_W-1:0] addr_first,
    input  logic [COM_ADDR_W-1:0] addr_last,
    output logic                  req,
    output logic [COM_ADDR_W-1:0] addr,
    input  logic                  rdy,
    input  logic [COM_DATA_W-1:0] data,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // ST_REQ here covers the whole read; the sub-module tracks REQ versus REL.
    hybd_state_t           state_q;
    logic [COM_ADDR_W-1:0] cur_q;
    logic [COM_ADDR_W-1:0] last_q;
    logic                  tx_valid_q;
    logic [7:0]            tx_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic                  launch_s;
    logic [COM_ADDR_W-1:0] launch_addr_s;
    logic [COM_DATA_W-1:0] word_s;
    logic                  rd_done_s;
    logic                  tmo_s;

    // Start a read on an accepted start or after the low byte of a non-final word.
    always_comb begin
        launch_s      = 1'b0;
        launch_addr_s = cur_q + 1'b1;
        if ((state_q == ST_IDLE) && start) begin
            launch_s      = 1'b1;
            launch_addr_s = addr_first;
        end else if ((state_q == ST_TX_LO) && tx_ready && (cur_q != last_q)) begin
            launch_s = 1'b1;
        end else begin
            launch_s = 1'b0;
        end
    end

    hybd_com_req_fsm #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TIMEOUT_W   (TIMEOUT_W)
    ) u_req_fsm (
        .clk_i         (core_clk),
        .reset_i       (reset),
        .launch_i      (launch_s),
        .launch_addr_i (launch_addr_s),
        .rdy_i         (rdy),
        .data_i        (data),
        .req_o         (req),
        .addr_o        (addr),
        .word_o        (word_s),
        .rd_done_o     (rd_done_s),
        .tmo_o         (tmo_s)
    );

    // Sweep sequencer and byte serializer.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            last_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tmo_s) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cur_q   <= addr_first;
                        last_q  <= addr_last;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (rd_done_s) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= word_s[15:8];
                        state_q    <= ST_TX_HI;
                    end
                end
                ST_TX_HI: begin
                    if (tx_ready) begin
                        tx_data_q <= word_s[7:0];
                        state_q   <= ST_TX_LO;
                    end
                end
                ST_TX_LO: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        if (cur_q == last_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            cur_q   <= cur_q + 1'b1;
                            state_q <= ST_REQ;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_hybd_com_reader.sv
// Self-checking bench for hybd_com_reader: behavioural responder, UART sink and byte/address scoreboard.
module tb_hybd_com_reader;

`ifdef COM_RD_TIMEOUT_EN
    localparam int TB_TMO = 15;
`else
    localparam int TB_TMO = 1023;
`endif

    logic        core_clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  addr_first = 7'd0;
    logic [6:0]  addr_last = 7'd0;
    logic        req;
    logic [6:0]  addr;
    logic        rdy;
    logic [15:0] data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    int resp_en = 1, rdy_delay = 1, rdy_hold = 0, data_mode = 1, bp_en = 0;
    logic [15:0] fixed_word = 16'h0000;

    logic [7:0] exp_byte_q[$];
    logic [6:0] exp_addr_q[$];
    logic [7:0] got_bytes[$];
    logic [6:0] got_addrs[$];
    logic [7:0] lit_b[$];
    logic [6:0] lit_a[$];

    hybd_com_reader #(.TIMEOUT_CYC(TB_TMO), .TIMEOUT_W(10)) dut (
        .core_clk(core_clk), .reset(reset), .start(start),
        .addr_first(addr_first), .addr_last(addr_last),
        .req(req), .addr(addr), .rdy(rdy), .data(data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 core_clk = ~core_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [6:0] a);
        if (data_mode == 0) return fixed_word;
        return 16'(a) * 16'h0101;
    endfunction

    // Model: a sweep reads ((last-first) mod 128)+1 consecutive addresses, two bytes each, MSB first.
    task automatic expect_sweep(input logic [6:0] f, input logic [6:0] l, input bit fill);
        int n;
        logic [6:0] a;
        logic [15:0] w;
        n = ((int'(l) - int'(f) + 128) % 128) + 1;
        for (int i = 0; i < n; i++) begin
            a = 7'((int'(f) + i) % 128);
            w = fill ? 16'hFFFF : word_of(a);
            exp_addr_q.push_back(a);
            exp_byte_q.push_back(w[15:8]);
            exp_byte_q.push_back(w[7:0]);
        end
    endtask

    task automatic clear_logs();
        got_bytes.delete();
        got_addrs.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [6:0] f, input logic [6:0] l);
        @(posedge core_clk); #1;
        start = 1'b1; addr_first = f; addr_last = l;
        @(posedge core_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge core_clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_in_budget", 32'(seen), 32'd1);
    endtask

    task automatic check_bytes(input string name);
        check({name, "_count"}, got_bytes.size(), lit_b.size());
        for (int i = 0; i < lit_b.size() && i < got_bytes.size(); i++)
            check(name, got_bytes[i], lit_b[i]);
    endtask

    // Responder: rdy after rdy_delay cycles of req, held rdy_hold cycles after req drops.
    initial begin
        int wcnt, hcnt;
        rdy = 1'b0; data = 16'h0000; wcnt = 0; hcnt = 0;
        forever begin
            @(posedge core_clk); #1;
            if (reset) begin
                rdy = 1'b0; wcnt = 0; hcnt = 0;
            end else if (!rdy) begin
                if (req && resp_en != 0) begin
                    wcnt++;
                    if (wcnt >= rdy_delay) begin
                        rdy = 1'b1; data = word_of(addr); wcnt = 0;
                    end
                end else begin
                    wcnt = 0;
                end
            end else if (!req) begin
                if (hcnt >= rdy_hold) begin
                    rdy = 1'b0; hcnt = 0;
                end else begin
                    hcnt++;
                end
            end
        end
    end

    // UART sink: always ready, or 20 cycles of backpressure per byte.
    initial begin
        int bcnt;
        tx_ready = 1'b1; bcnt = 0;
        forever begin
            @(posedge core_clk); #1;
            if (bp_en == 0) begin
                tx_ready = 1'b1; bcnt = 0;
            end else if (tx_ready) begin
                tx_ready = 1'b0; bcnt = 0;
            end else if (tx_valid) begin
                bcnt++;
                if (bcnt >= 20) tx_ready = 1'b1;
            end
        end
    end

    logic       prev_valid = 1'b0, prev_accept = 1'b0, prev_req = 1'b0, prev_rdy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [6:0] prev_addr = 7'd0;
    int         req_run = 0, last_req_len = 0;

    // Compare process: every cycle, check stream order, hold rules and handshake rules.
    always @(negedge core_clk) begin
        if (reset) begin
            prev_valid = 1'b0; prev_accept = 1'b0; prev_req = 1'b0; prev_rdy = 1'b0; req_run = 0;
        end else begin
            if (prev_valid && !prev_accept) begin
                check("tx_hold_valid", 32'(tx_valid), 32'd1);
                check("tx_hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid) check("busy_during_tx", 32'(busy), 32'd1);
            if (tx_valid && tx_ready) begin
                got_bytes.push_back(tx_data);
                if (exp_byte_q.size() == 0) check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
                else check("tx_byte", 32'(tx_data), 32'(exp_byte_q.pop_front()));
            end
            if (req && !prev_req) begin
                got_addrs.push_back(addr);
                check("req_raised_while_rdy", 32'(prev_rdy), 32'd0);
                if (exp_addr_q.size() == 0) check("unexpected_req", 32'(addr), 32'hFFFF_FFFF);
                else check("req_addr", 32'(addr), 32'(exp_addr_q.pop_front()));
            end
            if (req && prev_req) check("addr_stable", 32'(addr), 32'(prev_addr));
            if (req) req_run++;
            else if (prev_req) begin
                last_req_len = req_run; req_run = 0;
            end
            if (done) begin
                done_cnt++;
                check("done_busy_low", 32'(busy), 32'd0);
                check("done_all_bytes", 32'(exp_byte_q.size()), 32'd0);
            end
            prev_valid  = tx_valid;
            prev_accept = tx_valid && tx_ready;
            prev_data   = tx_data;
            prev_req    = req;
            prev_rdy    = rdy;
            prev_addr   = addr;
        end
    end

    initial begin
        bit found;
        reset = 1'b1;
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        check("rst_req", 32'(req), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge core_clk); #1;
        reset = 1'b0;

        // Single read at 0x05, rdy three cycles after req.
        data_mode = 0; fixed_word = 16'hA55A; rdy_delay = 3;
        clear_logs();
        expect_sweep(7'h05, 7'h05, 1'b0);
        pulse_start(7'h05, 7'h05);
        check("start_req", 32'(req), 32'd1);
        check("start_addr", 32'(addr), 32'h05);
        check("start_busy", 32'(busy), 32'd1);
        wait_done(200);
        @(posedge core_clk); #1;
        lit_b = '{8'hA5, 8'h5A};
        check_bytes("single_bytes");
        check("single_done_cnt", 32'(done_cnt), 32'd1);
        check("single_req_cnt", 32'(got_addrs.size()), 32'd1);
        check("single_err", 32'(err), 32'd0);

        // Sweep 0x10..0x13 with data = addr * 0x0101.
        data_mode = 1; rdy_delay = 1;
        clear_logs();
        expect_sweep(7'h10, 7'h13, 1'b0);
        pulse_start(7'h10, 7'h13);
        wait_done(400);
        @(posedge core_clk); #1;
        lit_b = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h13, 8'h13};
        check_bytes("sweep_bytes");
        check("sweep_done_cnt", 32'(done_cnt), 32'd1);

        // Wrap 0x7E..0x01, then a start coincident with done.
        clear_logs();
        expect_sweep(7'h7E, 7'h01, 1'b0);
        pulse_start(7'h7E, 7'h01);
        wait_done(400);
        start = 1'b1; addr_first = 7'h50; addr_last = 7'h50;
        @(posedge core_clk); #1;
        start = 1'b0;
        lit_a = '{7'h7E, 7'h7F, 7'h00, 7'h01};
        check("wrap_words", 32'(got_addrs.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_addrs.size(); i++)
            check("wrap_addr_seq", 32'(got_addrs[i]), 32'(lit_a[i]));
        check("wrap_bytes", 32'(got_bytes.size()), 32'd8);
        clear_logs();
        expect_sweep(7'h50, 7'h50, 1'b0);
        check("coinc_start_req", 32'(req), 32'd1);
        check("coinc_start_addr", 32'(addr), 32'h50);
        wait_done(200);

        // Backpressure: 20 cycles low on every byte.
        @(posedge core_clk); #1;
        bp_en = 1;
        clear_logs();
        expect_sweep(7'h20, 7'h21, 1'b0);
        pulse_start(7'h20, 7'h21);
        wait_done(600);
        bp_en = 0;
        @(posedge core_clk); #1;
        check("bp_byte_count", 32'(got_bytes.size()), 32'd4);

        // Responder holds rdy 6 cycles after req drops; stray start mid-sweep.
        rdy_hold = 6;
        clear_logs();
        expect_sweep(7'h30, 7'h32, 1'b0);
        pulse_start(7'h30, 7'h32);
        repeat (10) @(posedge core_clk);
        pulse_start(7'h40, 7'h45);
        wait_done(600);
        repeat (5) @(posedge core_clk);
        #1;
        check("hold_idle_req", 32'(req), 32'd0);
        check("hold_word_count", 32'(got_addrs.size()), 32'd3);
        rdy_hold = 0;

`ifdef COM_RD_TIMEOUT_EN
        // Responder silent: req must time out after TIMEOUT_CYC cycles.
        resp_en = 0;
        clear_logs();
        expect_sweep(7'h22, 7'h22, 1'b1);
        pulse_start(7'h22, 7'h22);
        wait_done(200);
        repeat (3) @(posedge core_clk);
        #1;
        check("tmo_req_len", 32'(last_req_len), 32'd15);
        check("tmo_err_sticky", 32'(err), 32'd1);
        lit_b = '{8'hFF, 8'hFF};
        check_bytes("tmo_bytes");
        resp_en = 1;
        expect_sweep(7'h23, 7'h23, 1'b0);
        pulse_start(7'h23, 7'h23);
        check("tmo_err_cleared", 32'(err), 32'd0);
        wait_done(200);
`endif

        // Synchronous reset while a high byte is waiting.
        @(posedge core_clk); #1;
        bp_en = 1;
        clear_logs();
        expect_sweep(7'h60, 7'h61, 1'b0);
        pulse_start(7'h60, 7'h61);
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge core_clk);
            if (tx_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_tx_hi", 32'(found), 32'd1);
        @(posedge core_clk); #1;
        reset = 1'b1;
        exp_byte_q.delete();
        exp_addr_q.delete();
        @(posedge core_clk); #1;
        check("mid_rst_req", 32'(req), 32'd0);
        check("mid_rst_addr", 32'(addr), 32'd0);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        bp_en = 0;

        // Recovery after reset.
        clear_logs();
        expect_sweep(7'h0A, 7'h0B, 1'b0);
        pulse_start(7'h0A, 7'h0B);
        wait_done(300);
        @(posedge core_clk); #1;
        lit_b = '{8'h0A, 8'h0A, 8'h0B, 8'h0B};
        check_bytes("recover_bytes");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
